riscv_iterative_alu: RTL and testbench
======================================

# riscv_iterative_alu

Execute-stage ALU for the RV32I core, directly downstream of the ALU control unit: consumes its 4-bit `ALUctrl` code ({func7[5], func3} for R-type, ADD for load/store, SUB for branch) plus two 32-bit operands. It produces a registered result and zero flag with a start/done handshake. Shifts run one bit per cycle to save area, so shift latency equals the shift amount; all other operations complete in one cycle.

## Interface
- No parameters.
- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request. Sampled only when idle (`busy`=0).
- `ALUctrl`  in  4  operation code from the ALU control unit.
- `A`  in  32  operand rs1 / address base.
- `B`  in  32  operand rs2 / immediate. Shift amount is `B[4:0]`.
- `busy`  out  1  high while a multi-cycle shift is in progress.
- `done`  out  1  one-cycle pulse. `result` and `zero` are valid from this cycle.
- `result`  out  32  registered result. Held until the next `done`.
- `zero`  out  1  registered (`result`==0). Used by the branch logic.

Clock/reset decision: one clock; reset is asynchronous and active-low.

## Operation
- **Codes:**
  - 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT (signed), 0011 SLTU.
  - 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND.
  - Any other code executes ADD.
- **Arithmetic:** all arithmetic is 32-bit modulo 2^32, with carry and overflow discarded. SLT/SLTU write 32'h1 or 32'h0.
- **Operand capture:** `A`, `B[4:0]` and `ALUctrl` are captured on an accepted start. Inputs may change afterwards without effect.
- **FSM states:** IDLE, SHIFT.
  - **IDLE + start, non-shift op or shamt=0:** compute and register `result`/`zero`, pulse `done` next cycle, stay IDLE.
  - **IDLE + start, shift op with shamt≥1:**
    - Load the accumulator with the operand shifted by 1 and set the counter to shamt−1.
    - If the counter is now 0, pulse `done` next cycle and stay IDLE. Otherwise go to SHIFT.
  - **SHIFT:** shift the accumulator by 1 each cycle and decrement the counter. When the counter reaches 0, register the result, pulse `done` and return to IDLE.
- **Shift fill:** SRA fills with the captured `A[31]`. SRL and SLL fill with 0.
- **Start while busy:** `start` while `busy`=1 is ignored and not queued.
- **Reset values:** `busy`=0, `done`=0, `result`=0, `zero`=1, FSM=IDLE, counter=0.
- **Reset mid-shift:** abandons the operation immediately. No `done` is produced.

## Timing
- `start` is high in cycle 0 and sampled at the end of cycle 0.
- **Latency L:**
  - `done` and the new `result`/`zero` appear in cycle L.
  - L = 1 for non-shift ops and for shamt=0.
  - L = shamt (1–31) for shifts.
- **busy:** high in cycles 1..L−1 only, so never high for L=1.
- **Back-to-back:** the FSM is IDLE in the `done` cycle, so `start` in that cycle is accepted. Sustained one op per cycle is possible for non-shift ops.
- **Register boundary:** there is no combinational path from inputs to outputs. All outputs come straight from flops.

## Configuration
- **`RISCV_ALU_BARREL_SHIFT_EN` defined:**
  - Shifts use a single-cycle barrel shifter, and L = 1 for every op.
  - The SHIFT state and the counter are removed. `busy` is tied to 0.
- **Not defined:** iterative shifter as described above.
- Handshake, reset values and results are identical in both builds.

## Test plan
- ADD, A=5, B=7, start in cycle 0 → `done` in cycle 1, `result`=12, `zero`=0, `busy` never high.
- SUB, A=B=0x1234 → `result`=0, `zero`=1 in cycle 1. Unused code 1111 with A=3, B=4 → `result`=7.
- SRA, A=0x80000000, B=4 → `busy` high in cycles 1–3, `done` in cycle 4, `result`=0xF8000000. Same stimulus with SRL → 0x08000000.
- SLL, A=1, B=31 → `done` in cycle 31, `result`=0x80000000. Second start with ADD in the `done` cycle → accepted, its `done` in cycle 32.
- SLL, A=1, B=10, with `start` re-pulsed with ADD in cycle 3 → ignored, single `done` in cycle 10, `result`=0x400. Repeat with `rst_n` low in cycle 5 → outputs reset, no `done`.
- With `RISCV_ALU_BARREL_SHIFT_EN`: SRA, A=0x80000000, B=31 → `done` in cycle 1, `result`=0xFFFFFFFF, `busy` stays 0.

Source files
------------

// File: rtl/riscv_iterative_alu.sv
// rtl/riscv_iterative_alu.sv - RV32I execute-stage ALU with iterative (or optional barrel) shifter
//
// Ports:
//   clk      core clock, rising edge
//   rst_n    asynchronous active-low reset
//   start    operation request, accepted only while busy=0
//   ALUctrl  4-bit op code {func7[5], func3}; unknown codes execute ADD
//   A, B     operands; shift amount is B[4:0]
//   busy     high while a multi-cycle shift is running
//   done     one-cycle pulse when result/zero are updated
//   result   registered result, held until the next done
//   zero     registered (result == 0)
//
// Build option: define RISCV_ALU_BARREL_SHIFT_EN to replace the one-bit-per-cycle
// shifter with a single-cycle barrel shifter (busy then stays 0).
module riscv_iterative_alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  ALUctrl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        zero
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;

    // Single-cycle result. In the iterative build shift codes only reach
    // here with shamt=0, so they simply pass A through.
    function automatic logic [31:0] compute(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            OP_SUB:  compute = a - b;
            OP_SLT:  compute = {31'b0, ($signed(a) < $signed(b))};
            OP_SLTU: compute = {31'b0, (a < b)};
            OP_XOR:  compute = a ^ b;
            OP_OR:   compute = a | b;
            OP_AND:  compute = a & b;
`ifdef RISCV_ALU_BARREL_SHIFT_EN
            OP_SLL:  compute = a << b[4:0];
            OP_SRL:  compute = a >> b[4:0];
            OP_SRA:  compute = $signed(a) >>> b[4:0];
`else
            OP_SLL:  compute = a;
            OP_SRL:  compute = a;
            OP_SRA:  compute = a;
`endif
            default: compute = a + b;
        endcase
    endfunction

`ifdef RISCV_ALU_BARREL_SHIFT_EN

    assign busy = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done   <= 1'b0;
            result <= 32'h0;
            zero   <= 1'b1;
        end else begin
            done <= 1'b0;
            if (start) begin
                result <= compute(ALUctrl, A, B);
                zero   <= (compute(ALUctrl, A, B) == 32'h0);
                done   <= 1'b1;
            end
        end
    end

`else

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] result_d;
    logic        zero_d, done_d;
    logic [31:0] first_step, acc_step;

    // One-bit shift step. SRA replicates bit 31, which is always the
    // captured A[31] because the MSB never changes during SRA.
    function automatic logic [31:0] shift1(input logic [31:0] v, input logic [3:0] op);
        case (op)
            OP_SLL:  shift1 = {v[30:0], 1'b0};
            OP_SRA:  shift1 = {v[31], v[31:1]};
            default: shift1 = {1'b0, v[31:1]};
        endcase
    endfunction

    assign first_step = shift1(A, ALUctrl);
    assign acc_step   = shift1(acc_q, op_q);
    assign busy       = (state_q == SHIFT);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        result_d = result;
        zero_d   = zero;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d = ALUctrl;
                    if ((ALUctrl == OP_SLL || ALUctrl == OP_SRL || ALUctrl == OP_SRA) &&
                        (B[4:0] != 5'd0)) begin
                        acc_d = first_step;
                        cnt_d = B[4:0] - 5'd1;
                        if (B[4:0] == 5'd1) begin
                            result_d = first_step;
                            zero_d   = (first_step == 32'h0);
                            done_d   = 1'b1;
                        end else begin
                            state_d = SHIFT;
                        end
                    end else begin
                        result_d = compute(ALUctrl, A, B);
                        zero_d   = (compute(ALUctrl, A, B) == 32'h0);
                        done_d   = 1'b1;
                    end
                end
            end
            SHIFT: begin
                acc_d = acc_step;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    result_d = acc_step;
                    zero_d   = (acc_step == 32'h0);
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= 32'h0;
            cnt_q   <= 5'd0;
            op_q    <= OP_ADD;
            result  <= 32'h0;
            zero    <= 1'b1;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            result  <= result_d;
            zero    <= zero_d;
            done    <= done_d;
        end
    end

`endif

endmodule

// File: tb/tb_riscv_iterative_alu.sv
// tb/tb_riscv_iterative_alu.sv - directed self-checking bench for riscv_iterative_alu
module tb_riscv_iterative_alu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  ALUctrl;
    logic [31:0] A, B;
    logic        busy, done;
    logic [31:0] result;
    logic        zero;

    int checks = 0;
    int errors = 0;

`ifdef RISCV_ALU_BARREL_SHIFT_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    riscv_iterative_alu dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .ALUctrl(ALUctrl),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .result (result),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives start for one cycle, scrambles the inputs afterwards, and
    // returns the cycle index of done (0 if it never came) plus busy count.
    task automatic exec(input bit wait_first, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt);
        if (wait_first) @(negedge clk);
        ALUctrl = op; A = a; B = b; start = 1'b1;
        lat = 0; busy_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0; ALUctrl = 4'b1000; A = 32'hA5A5_5A5A; B = 32'h0000_001F;
            if (busy) busy_cnt++;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic op_check(input string tag, input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp, input int exp_lat);
        int lat, bc;
        exec(1'b1, op, a, b, lat, bc);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy"}, 32'(bc), 32'(exp_lat - 1));
        check({tag, "_res"}, result, exp);
        check({tag, "_zero"}, {31'b0, zero}, {31'b0, exp == 32'h0});
    endtask

    initial begin
        int lat, bc, ndone, dcyc;
        rst_n = 1'b0; start = 1'b0; ALUctrl = 4'b0; A = 32'h0; B = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_result", result, 32'h0);
        check("rst_zero", {31'b0, zero}, 32'h1);
        rst_n = 1'b1;

        op_check("add", 4'b0000, 32'd5, 32'd7, 32'd12, 1);
        op_check("sub", 4'b1000, 32'h1234, 32'h1234, 32'h0, 1);
        op_check("unused", 4'b1111, 32'd3, 32'd4, 32'd7, 1);
        op_check("slt", 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
        op_check("sltu", 4'b0011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
        op_check("xor", 4'b0100, 32'hF0F0_1234, 32'h0FF0_4321, 32'hFF00_5115, 1);
        op_check("or", 4'b0110, 32'hF000_0001, 32'h0F00_0010, 32'hFF00_0011, 1);
        op_check("and", 4'b0111, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1);
        op_check("sll0", 4'b0001, 32'h1234_5678, 32'hFFFF_FFE0, 32'h1234_5678, 1);
        op_check("sra1", 4'b1101, 32'h8000_0000, 32'd1, 32'hC000_0000, 1);
        op_check("sra4", 4'b1101, 32'h8000_0000, 32'd4, 32'hF800_0000, BARREL ? 1 : 4);
        op_check("srl4", 4'b0101, 32'h8000_0000, 32'd4, 32'h0800_0000, BARREL ? 1 : 4);
        op_check("sra31", 4'b1101, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, BARREL ? 1 : 31);

        // SLL by 31, then ADD issued in the done cycle.
        exec(1'b1, 4'b0001, 32'd1, 32'd31, lat, bc);
        check("sll31_lat", 32'(lat), BARREL ? 32'd1 : 32'd31);
        check("sll31_res", result, 32'h8000_0000);
        exec(1'b0, 4'b0000, 32'd100, 32'd23, lat, bc);
        check("b2b_lat", 32'(lat), 32'd1);
        check("b2b_res", result, 32'd123);

`ifndef RISCV_ALU_BARREL_SHIFT_EN
        // Start re-pulsed mid-shift must be dropped.
        @(negedge clk);
        ALUctrl = 4'b0001; A = 32'd1; B = 32'd10; start = 1'b1;
        ndone = 0; dcyc = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            start = (c == 3); ALUctrl = 4'b0000; A = 32'd9; B = 32'd9;
            if (done) begin
                ndone++;
                dcyc = c;
            end
        end
        check("ign_ndone", 32'(ndone), 32'd1);
        check("ign_cycle", 32'(dcyc), 32'd10);
        check("ign_res", result, 32'h400);

        // Reset asserted in cycle 5 of a shift.
        @(negedge clk);
        ALUctrl = 4'b0001; A = 32'd1; B = 32'd10; start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("mid_busy_before", {31'b0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'b0, busy}, 32'h0);
        check("mid_rst_result", result, 32'h0);
        check("mid_rst_zero", {31'b0, zero}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("mid_no_done", 32'(ndone), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
